cop0_state_unit: RTL
====================

// Module: cop0_state_unit
// PURPOSE
//  Architectural CP0 state for the pipeline: BadVAddr, Count, Compare, Status, Cause and EPC.
//  Executes MTC0 writes, serves MFC0 reads, and records exceptions and ERET.
//  Samples a parametrised number of hardware interrupt lines and raises the pending-interrupt
//  flag to the exception logic. Sits beside the writeback stage, driven by the decoded
//  write_cop0 / eret / exception controls.
// PARAMETERS
//  N_HW_INT   6  number of hardware interrupt lines, 1..6; mapped to Cause.IP[2 +: N_HW_INT]
//  COUNT_DIV  2  clock cycles per Count increment, >=1
// PORTS
//  clk            in   1   clock; all state updates on its rising edge
//  reset          in   1   synchronous reset, active high
//  we             in   1   MTC0 write strobe
//  waddr          in   5   MTC0 rd field
//  wsel           in   3   MTC0 sel field
//  wdata          in   32  MTC0 data
//  raddr          in   5   MFC0 rd field
//  rsel           in   3   MFC0 sel field
//  rdata          out  32  MFC0 read data, combinational from current state
//  exc_valid      in   1   exception commits this cycle
//  exc_code       in   5   ExcCode; 0 = interrupt
//  exc_pc         in   32  PC of the faulting instruction
//  exc_bd         in   1   faulting instruction sits in a delay slot
//  exc_bva_valid  in   1   exc_badvaddr is meaningful
//  exc_badvaddr   in   32  faulting address
//  eret           in   1   ERET commits this cycle
//  hw_int         in   N_HW_INT  level-sensitive interrupt requests
//  epc_out        out  32  current EPC (ERET target)
//  status_exl     out  1   Status.EXL
//  int_pending    out  1   unmasked interrupt pending
// BEHAVIOUR
//  Reset values:
//   Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
//   Cause, EPC, BadVAddr, Count and Compare = 0; prescaler = 0.
//   Outputs follow from these values.
//  Reads (sel=0):
//   8 = BadVAddr, 9 = Count, 11 = Compare, 12 = Status, 13 = Cause, 14 = EPC.
//   Any other rd/sel reads 0. A read returns the pre-write value in the cycle of a write.
//  Writes land on the next edge. Writable fields:
//   Status: IM[15:8], EXL[1], IE[0]; BEV is read-only.
//   Cause: IP[9:8] only.
//   EPC, Count and Compare: full 32 bits.
//   Other addresses: write ignored.
//  Per-cycle priority: reset > exc_valid > eret > we. A lower-priority event is dropped
//   entirely in that cycle. Count advancing is independent of these events.
//  Exception:
//   Status.EXL <= 1; Cause.ExcCode <= exc_code.
//   If EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
//   If EXL was 1: EPC and BD are unchanged.
//   BadVAddr <= exc_badvaddr only when exc_bva_valid.
//  ERET: Status.EXL <= 0. EPC is unchanged.
//  Cause.IP[2+:N_HW_INT] <= hw_int every cycle (1-cycle latency); unused IP bits read 0.
//  int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational from
//   registered state.
// CONFIGURATION
//  COP0_TIMER_INT_EN defined:
//   Prescaler counts 0..COUNT_DIV-1. On wrap, Count += 1, wrapping at 2^32.
//   An MTC0 write to Count clears the prescaler.
//   When an increment makes Count == Compare, Cause.TI[30] and IP[7] are set.
//   An MTC0 write to Compare clears TI/IP[7].
//   IP[7] = TI OR hw_int[5] when N_HW_INT==6.
//  COP0_TIMER_INT_EN undefined:
//   No Count/Compare/prescaler logic. Reads of 9 and 11 return 0; writes are ignored.
//   TI = 0.
// STRUCTURE
//  Package cop0 holds:
//   - register address constants (BADVADDR, COUNT, COMPARE, STATUS, CAUSE, EPC);
//   - the ExcCode enum;
//   - Status/Cause bit-position constants and their writable masks;
//   - packed status_t / cause_t typedefs.
//  Sub-module cop0_timer holds the prescaler, Count and Compare. It outputs timer_hit and
//   count/compare read data. It is instantiated only under COP0_TIMER_INT_EN.
// TESTING
//  reset, then read 12 -> 32'h0040_0000. Read 13 -> 0. int_pending=0.
//  MTC0 Status=32'h0000_0401 with hw_int[0]=1 -> next cycle Cause.IP[2]=1; following cycle
//   int_pending=1.
//  exc_valid with exc_pc=32'h8000_0010, exc_bd=1, code=4 -> EPC=32'h8000_000C, BD=1,
//   ExcCode=4, EXL=1, int_pending=0.
//  Second exception while EXL=1 -> EPC unchanged. In a separate cycle, exc_valid with
//   eret=1 -> EXL stays 1.
//  (TIMER_EN, COUNT_DIV=2) Compare=5, Count=3 -> TI set 4 cycles later. MTC0 Compare
//   -> TI=0.
//  MTC0 with waddr=14 and exc_valid in the same cycle -> EPC takes the exception value.
//   Read of rd=7 -> 0.

Source files
------------

// File: rtl/cop0_state_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause layouts
// and their software-writable masks.
package cop0;

  localparam logic [4:0] BADVADDR = 5'd8;
  localparam logic [4:0] COUNT    = 5'd9;
  localparam logic [4:0] COMPARE  = 5'd11;
  localparam logic [4:0] STATUS   = 5'd12;
  localparam logic [4:0] CAUSE    = 5'd13;
  localparam logic [4:0] EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_BEV    = 22;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_BD      = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [5:0] rsvd_lo;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cause_t;

endpackage

// File: rtl/cop0_state_unit_if.sv
// Pipeline-facing CP0 bus: MTC0/MFC0 access, exception/ERET commit and interrupt lines.
interface cop0_state_unit_if #(
  parameter int N_HW_INT = 6
);
  logic                we;
  logic [4:0]          waddr;
  logic [2:0]          wsel;
  logic [31:0]         wdata;
  logic [4:0]          raddr;
  logic [2:0]          rsel;
  logic [31:0]         rdata;
  logic                exc_valid;
  logic [4:0]          exc_code;
  logic [31:0]         exc_pc;
  logic                exc_bd;
  logic                exc_bva_valid;
  logic [31:0]         exc_badvaddr;
  logic                eret;
  logic [N_HW_INT-1:0] hw_int;
  logic [31:0]         epc_out;
  logic                status_exl;
  logic                int_pending;

  modport master (
    output we, waddr, wsel, wdata, raddr, rsel,
    output exc_valid, exc_code, exc_pc, exc_bd, exc_bva_valid, exc_badvaddr,
    output eret, hw_int,
    input  rdata, epc_out, status_exl, int_pending
  );

  modport slave (
    input  we, waddr, wsel, wdata, raddr, rsel,
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_bva_valid, exc_badvaddr,
    input  eret, hw_int,
    output rdata, epc_out, status_exl, int_pending
  );
endinterface

// File: rtl/cop0_state_unit_timer.sv
// Count/Compare timer with a COUNT_DIV prescaler; timer_hit_o flags an increment
// that lands Count on Compare.
module cop0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_hit_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          tick;

  assign tick = (presc_q == PW'(COUNT_DIV - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    if (count_we_i) begin
      presc_d = '0;
      count_d = wdata_i;
    end
    if (compare_we_i) compare_d = wdata_i;
  end

  // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  // A software write to Count replaces the increment, so it can never hit.
  assign timer_hit_o = tick & ~count_we_i & ((count_q + 32'd1) == compare_q);
  assign count_o     = count_q;
  assign compare_o   = compare_q;

endmodule

// File: rtl/cop0_state_unit.sv
// Architectural CP0 state (BadVAddr, Count, Compare, Status, Cause, EPC).
// Timer logic is built only when COP0_TIMER_INT_EN is defined.
module cop0_state_unit
  import cop0::*;
#(
  parameter int N_HW_INT  = 6,
  parameter int COUNT_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  cop0_state_unit_if.slave   bus
);

  if (N_HW_INT < 1 || N_HW_INT > 6) begin : g_bad_n_hw_int
    $error("cop0_state_unit: N_HW_INT must be in 1..6");
  end
  if (COUNT_DIV < 1) begin : g_bad_count_div
    $error("cop0_state_unit: COUNT_DIV must be >= 1");
  end

  status_t     status_q, status_d;
  cause_t      cause_q, cause_d, cause_rd;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  // Priority exception > ERET > MTC0; the losers are dropped for this cycle.
  logic exc_take, eret_take, wr_take;
  assign exc_take  = bus.exc_valid;
  assign eret_take = bus.eret & ~bus.exc_valid;
  assign wr_take   = bus.we & ~bus.exc_valid & ~bus.eret & (bus.wsel == 3'd0);

`ifdef COP0_TIMER_INT_EN
  logic        wr_count, wr_compare, timer_hit;
  logic [31:0] count_rd, compare_rd;
  assign wr_count   = wr_take & (bus.waddr == COUNT);
  assign wr_compare = wr_take & (bus.waddr == COMPARE);

  cop0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (bus.wdata),
    .count_o      (count_rd),
    .compare_o    (compare_rd),
    .timer_hit_o  (timer_hit)
  );
`endif

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d.ip[7:2] = '0;
    for (int i = 0; i < N_HW_INT; i++) cause_d.ip[2+i] = bus.hw_int[i];

    if (exc_take) begin
      status_d.exl     = 1'b1;
      cause_d.exc_code = bus.exc_code;
      // A nested exception keeps the original return point.
      if (!status_q.exl) begin
        epc_d      = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        cause_d.bd = bus.exc_bd;
      end
      if (bus.exc_bva_valid) badvaddr_d = bus.exc_badvaddr;
    end else if (eret_take) begin
      status_d.exl = 1'b0;
    end else if (wr_take) begin
      case (bus.waddr)
        STATUS:  status_d = status_t'((status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK));
        CAUSE:   cause_d.ip[1:0] = bus.wdata[CAUSE_IP_LO +: 2];
        EPC:     epc_d = bus.wdata;
        default: ;
      endcase
    end

`ifdef COP0_TIMER_INT_EN
    if (wr_compare)     cause_d.ti = 1'b0;
    else if (timer_hit) cause_d.ti = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= status_t'(STATUS_RESET);
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // IP[7] is shared between the timer and the top hardware line.
  always_comb begin
    cause_rd       = cause_q;
    cause_rd.ip[7] = cause_q.ip[7] | cause_q.ti;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rsel == 3'd0) begin
      case (bus.raddr)
        BADVADDR: bus.rdata = badvaddr_q;
        STATUS:   bus.rdata = status_q;
        CAUSE:    bus.rdata = cause_rd;
        EPC:      bus.rdata = epc_q;
`ifdef COP0_TIMER_INT_EN
        COUNT:    bus.rdata = count_rd;
        COMPARE:  bus.rdata = compare_rd;
`endif
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign bus.epc_out     = epc_q;
  assign bus.status_exl  = status_q.exl;
  assign bus.int_pending = status_q.ie & ~status_q.exl & (|(cause_rd.ip & status_q.im));

endmodule
